// File: rtl/fwd_hazard_pipe.sv
// ID-stage forwarding-select precompute with load-use stall FSM and stall counter.
// Selects are registered so EX sees them with no compare path in front of its operand muxes.
module fwd_hazard_pipe #(
  parameter int REG_AW   = 5,
  parameter int NUM_SRC  = 2,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_SRC*REG_AW-1:0] id_src_i,
  input  logic                      id_valid_i,
  input  logic [REG_AW-1:0]         idex_rd_i,
  input  logic                      idex_wr_i,
  input  logic                      idex_memrd_i,
  input  logic [REG_AW-1:0]         exmem_rd_i,
  input  logic                      exmem_wr_i,
  input  logic                      flush_i,
  output logic [2*NUM_SRC-1:0]      fwd_sel_o,
  output logic                      stall_o,
  output logic                      idex_bubble_o,
  output logic [CNT_W-1:0]          stall_cnt_o
);

  typedef enum logic {IDLE, STALL} state_t;

  localparam logic [2:0] LAT_M1 = 3'(LOAD_LAT - 1);

  state_t               state_q, state_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [2*NUM_SRC-1:0] sel_q, sel_d, sel_calc;
  logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;
  logic [NUM_SRC-1:0]   hit_ex;
  logic                 load_use;
  logic                 stall;

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic [REG_AW-1:0] src;
      logic              hit_mem;
      assign src        = id_src_i[gi*REG_AW +: REG_AW];
      assign hit_ex[gi] = idex_wr_i && (idex_rd_i != '0) && (src == idex_rd_i);
      assign hit_mem    = exmem_wr_i && (exmem_rd_i != '0) && (src == exmem_rd_i) && !hit_ex[gi];
      assign sel_calc[2*gi +: 2] = hit_ex[gi] ? 2'b10 : (hit_mem ? 2'b01 : 2'b00);
    end
  endgenerate

  assign load_use = id_valid_i && !flush_i && idex_memrd_i && (|hit_ex);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall       = 1'b0;
    if (flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_use) begin
            stall = 1'b1;
            if (LOAD_LAT > 1) begin
              state_d = STALL;
              cnt_d   = LAT_M1;
            end
          end
        end
        STALL: begin
          // cnt holds the number of stall cycles still owed, this one included
          stall = 1'b1;
          if (cnt_q <= 3'd1) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    if (rst_i) begin
      stall = 1'b0;
    end

    sel_d = (stall || flush_i || !id_valid_i) ? '0 : sel_calc;

    stall_cnt_d = stall_cnt_q;
    if (stall && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sel_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fwd_sel_o     = sel_q;
  assign stall_o       = stall;
  assign idex_bubble_o = stall;
  assign stall_cnt_o   = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_pipe.sv
// Scoreboard bench: two instances (LOAD_LAT=1/CNT_W=16 and LOAD_LAT=3/CNT_W=4) share stimulus;
// a queue of expected per-cycle outputs from a rule-level model is drained by a monitor.
module tb_fwd_hazard_pipe;

  logic        clk;
  logic        rst;
  logic [9:0]  id_src;
  logic        id_valid;
  logic [4:0]  ex_rd;
  logic        ex_wr;
  logic        ex_memrd;
  logic [4:0]  mem_rd;
  logic        mem_wr;
  logic        flush;

  logic [3:0]  sel_a, sel_b;
  logic        stall_a, stall_b, bub_a, bub_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  fwd_hazard_pipe #(.REG_AW(5), .NUM_SRC(2), .LOAD_LAT(1), .CNT_W(16)) dut_a (
    .clk_i(clk), .rst_i(rst), .id_src_i(id_src), .id_valid_i(id_valid),
    .idex_rd_i(ex_rd), .idex_wr_i(ex_wr), .idex_memrd_i(ex_memrd),
    .exmem_rd_i(mem_rd), .exmem_wr_i(mem_wr), .flush_i(flush),
    .fwd_sel_o(sel_a), .stall_o(stall_a), .idex_bubble_o(bub_a), .stall_cnt_o(cnt_a)
  );

  fwd_hazard_pipe #(.REG_AW(5), .NUM_SRC(2), .LOAD_LAT(3), .CNT_W(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .id_src_i(id_src), .id_valid_i(id_valid),
    .idex_rd_i(ex_rd), .idex_wr_i(ex_wr), .idex_memrd_i(ex_memrd),
    .exmem_rd_i(mem_rd), .exmem_wr_i(mem_wr), .flush_i(flush),
    .fwd_sel_o(sel_b), .stall_o(stall_b), .idex_bubble_o(bub_b), .stall_cnt_o(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] s0, s1, ex_rd, mem_rd;
    logic       valid, ex_wr, memrd, mem_wr, flush, rst;
  } stim_t;

  typedef struct {
    int          cyc;
    logic        stall_a, stall_b;
    logic [3:0]  sel_a, sel_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  // Reference state: how many more forced stall cycles each instance owes, its count, its EX select
  int         left_a = 0, left_b = 0;
  int         mcnt_a = 0, mcnt_b = 0;
  logic [3:0] msel_a = '0, msel_b = '0;

  function automatic stim_t mk(input int s0, input int s1, input bit valid,
                               input int erd, input bit ewr, input bit memrd,
                               input int mrd, input bit mwr, input bit fl, input bit rs);
    stim_t s;
    s.s0 = 5'(s0); s.s1 = 5'(s1); s.valid = valid;
    s.ex_rd = 5'(erd); s.ex_wr = ewr; s.memrd = memrd;
    s.mem_rd = 5'(mrd); s.mem_wr = mwr; s.flush = fl; s.rst = rs;
    return s;
  endfunction

  function automatic bit writes_ex(input stim_t s, input logic [4:0] src);
    return s.ex_wr && s.ex_rd != 0 && src == s.ex_rd;
  endfunction

  function automatic logic [1:0] op_sel(input stim_t s, input logic [4:0] src);
    if (writes_ex(s, src)) return 2'b10;
    if (s.mem_wr && s.mem_rd != 0 && src == s.mem_rd) return 2'b01;
    return 2'b00;
  endfunction

  task automatic stall_rule(input int lat, input bit det, input bit fl,
                            inout int left, output logic st);
    if (fl) begin
      st = 1'b0; left = 0;
    end else if (left > 0) begin
      st = 1'b1; left = left - 1;
    end else if (det) begin
      st = 1'b1; left = lat - 1;
    end else begin
      st = 1'b0;
    end
  endtask

  task automatic apply(input stim_t s);
    exp_t       e;
    logic       st_a, st_b;
    logic [3:0] calc;
    bit         det;
    @(negedge clk);
    id_src   = {s.s1, s.s0};
    id_valid = s.valid;
    ex_rd    = s.ex_rd;  ex_wr  = s.ex_wr;  ex_memrd = s.memrd;
    mem_rd   = s.mem_rd; mem_wr = s.mem_wr;
    flush    = s.flush;  rst    = s.rst;
    cyc++;
    e.cyc = cyc;
    if (s.rst) begin
      left_a = 0; left_b = 0; mcnt_a = 0; mcnt_b = 0; msel_a = '0; msel_b = '0;
      e.stall_a = 0; e.stall_b = 0; e.sel_a = '0; e.sel_b = '0; e.cnt_a = '0; e.cnt_b = '0;
      exp_q.push_back(e);
      return;
    end
    calc = {op_sel(s, s.s1), op_sel(s, s.s0)};
    det  = s.valid && !s.flush && s.memrd && (writes_ex(s, s.s0) || writes_ex(s, s.s1));
    stall_rule(1, det, s.flush, left_a, st_a);
    stall_rule(3, det, s.flush, left_b, st_b);
    e.stall_a = st_a; e.stall_b = st_b;
    e.sel_a = msel_a; e.sel_b = msel_b;
    e.cnt_a = 16'(mcnt_a); e.cnt_b = 4'(mcnt_b);
    exp_q.push_back(e);
    msel_a = (st_a || s.flush || !s.valid) ? 4'b0 : calc;
    msel_b = (st_b || s.flush || !s.valid) ? 4'b0 : calc;
    if (st_a && mcnt_a < 65535) mcnt_a++;
    if (st_b && mcnt_b < 15) mcnt_b++;
  endtask

  task automatic chk(input string name, input int c, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, exp);
    end
  endtask

  // Monitor: outputs are valid every cycle; sample mid-cycle, well clear of both edges
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("stall_a",  e.cyc, 16'(stall_a), 16'(e.stall_a));
        chk("bubble_a", e.cyc, 16'(bub_a),   16'(e.stall_a));
        chk("sel_a",    e.cyc, 16'(sel_a),   16'(e.sel_a));
        chk("cnt_a",    e.cyc, cnt_a,        e.cnt_a);
        chk("stall_b",  e.cyc, 16'(stall_b), 16'(e.stall_b));
        chk("bubble_b", e.cyc, 16'(bub_b),   16'(e.stall_b));
        chk("sel_b",    e.cyc, 16'(sel_b),   16'(e.sel_b));
        chk("cnt_b",    e.cyc, 16'(cnt_b),   16'(e.cnt_b));
      end
    end
  end

  initial begin
    stim_t idle, haz;
    rst = 1'b1; id_src = '0; id_valid = 0; ex_rd = '0; ex_wr = 0; ex_memrd = 0;
    mem_rd = '0; mem_wr = 0; flush = 0;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    haz  = mk(5, 0, 1, 5, 1, 1, 0, 0, 0, 0);

    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    apply(idle);
    // EX forward on src0 only
    apply(mk(3, 4, 1, 3, 1, 0, 0, 0, 0, 0)); apply(idle);
    // youngest writer wins, then MEM-only forward
    apply(mk(0, 3, 1, 3, 1, 0, 3, 1, 0, 0));
    apply(mk(0, 3, 1, 3, 0, 0, 3, 1, 0, 0)); apply(idle);
    // r0 never forwards and never stalls
    apply(mk(0, 0, 1, 0, 1, 1, 0, 1, 0, 0)); apply(idle);
    // load-use, then the load moves to MEM
    apply(haz);
    apply(mk(5, 0, 1, 0, 0, 0, 5, 1, 0, 0));
    for (int i = 0; i < 4; i++) apply(idle);
    // flush in the second stall cycle
    apply(haz);
    apply(mk(5, 0, 1, 5, 1, 1, 0, 0, 1, 0));
    apply(idle); apply(idle);
    // reset mid-stall
    apply(haz); apply(haz);
    apply(mk(5, 0, 1, 5, 1, 1, 0, 0, 0, 1));
    apply(idle); apply(idle);
    // both operands on the same load, held for saturation of the narrow counter
    for (int i = 0; i < 20; i++) apply(mk(5, 5, 1, 5, 1, 1, 0, 0, 0, 0));
    apply(idle);

    for (int i = 0; i < 800; i++) begin
      stim_t s;
      s = mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 7) != 0,
             $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 3), $urandom_range(0, 1),
             $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0);
      apply(s);
    end
    apply(idle);
    @(negedge clk);
    @(negedge clk);
    #4;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries never compared", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
